// File: rtl/il_debug_sequencer.sv
// Debug command sequencer driving the interruption logic's clk_en, breakpoint and clk_step.
// Optional auto-halt on break_in rising edge with sticky status bit: define IL_SEQ_AUTO_HALT_EN.
module il_debug_sequencer #(
   parameter int unsigned CNT_W     = 32,
   parameter int unsigned STEP_HIGH = 4,
   parameter int unsigned STEP_LOW  = 4
) (
   input  logic             sys_clk,
   input  logic             sys_reset_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [CNT_W-1:0] cmd_arg,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [CNT_W-1:0] rsp_data,
   input  logic             break_in,
   output logic             clk_en,
   output logic [CNT_W-1:0] breakpoint,
   output logic             clk_step
);

   localparam int unsigned TMR_MAX = (STEP_HIGH > STEP_LOW) ? STEP_HIGH : STEP_LOW;
   localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

   typedef enum logic [1:0] {IDLE, STEP_HI, STEP_LO, RESP} state_e;
   typedef enum logic [2:0] {
      OP_NOP, OP_SET_BP, OP_RUN, OP_HALT, OP_STEP, OP_RD_STATUS, OP_RD_CYCLES, OP_CLR_CYCLES
   } op_e;

   state_e           state_q, state_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic [CNT_W-1:0] steps_q, steps_d;
   logic [CNT_W-1:0] bp_q, bp_d;
   logic [CNT_W-1:0] cyc_q, cyc_d;
   logic [CNT_W-1:0] rsp_q, rsp_d;
   logic             clk_en_q, clk_en_d;
   logic             clk_step_q, clk_step_d;
   logic             accept, clr_cyc, cyc_inc, step_entry, sticky;
   op_e              op;

   assign op         = op_e'(cmd_op);
   assign cmd_ready  = sys_reset_n & (state_q == IDLE);
   assign accept     = cmd_valid & cmd_ready;
   assign rsp_valid  = (state_q == RESP);
   assign rsp_data   = rsp_q;
   assign clk_en     = clk_en_q;
   assign breakpoint = bp_q;
   assign clk_step   = clk_step_q;

`ifdef IL_SEQ_AUTO_HALT_EN
   logic brk_q, sticky_q, sticky_d, rsp_stat_q, rsp_stat_d, brk_rise, status_hs;

   assign brk_rise   = break_in & ~brk_q;
   assign status_hs  = (state_q == RESP) & rsp_ready & rsp_stat_q;
   assign sticky_d   = (sticky_q & ~status_hs) | brk_rise;
   assign rsp_stat_d = accept ? (op == OP_RD_STATUS) : rsp_stat_q;
   assign sticky     = sticky_q;

   always_ff @(posedge sys_clk or negedge sys_reset_n) begin
      if (!sys_reset_n) begin
         brk_q      <= 1'b0;
         sticky_q   <= 1'b0;
         rsp_stat_q <= 1'b0;
      end else begin
         brk_q      <= break_in;
         sticky_q   <= sticky_d;
         rsp_stat_q <= rsp_stat_d;
      end
   end
`else
   assign sticky = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      tmr_d    = tmr_q;
      steps_d  = steps_q;
      bp_d     = bp_q;
      rsp_d    = rsp_q;
      clk_en_d = clk_en_q;
      clr_cyc  = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               case (op)
                  OP_SET_BP:     bp_d     = cmd_arg;
                  OP_RUN:        clk_en_d = 1'b1;
                  OP_HALT:       clk_en_d = 1'b0;
                  OP_CLR_CYCLES: clr_cyc  = 1'b1;
                  OP_STEP: begin
                     if (cmd_arg != '0) begin
                        steps_d = cmd_arg;
                        tmr_d   = '0;
                        state_d = STEP_HI;
                     end
                  end
                  OP_RD_STATUS: begin
                     rsp_d   = {{(CNT_W-4){1'b0}}, sticky, 1'b0, break_in, clk_en_q};
                     state_d = RESP;
                  end
                  OP_RD_CYCLES: begin
                     rsp_d   = cyc_q;
                     state_d = RESP;
                  end
                  default: ;
               endcase
            end
         end
         STEP_HI: begin
            if (tmr_q == TMR_W'(STEP_HIGH - 1)) begin
               tmr_d   = '0;
               steps_d = steps_q - CNT_W'(1);
               state_d = STEP_LO;
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
            end
         end
         STEP_LO: begin
            if (tmr_q == TMR_W'(STEP_LOW - 1)) begin
               tmr_d   = '0;
               state_d = (steps_q != '0) ? STEP_HI : IDLE;
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
            end
         end
         RESP: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
`ifdef IL_SEQ_AUTO_HALT_EN
      // a break edge overrides any RUN accepted in the same cycle
      if (brk_rise) clk_en_d = 1'b0;
`endif
   end

   // clk_step is registered from the next state so it is high exactly while in STEP_HI
   assign clk_step_d = (state_d == STEP_HI);
   assign step_entry = (state_d == STEP_HI) & (state_q != STEP_HI);
   assign cyc_inc    = clk_en_q & ~break_in;
   assign cyc_d      = clr_cyc ? '0 : cyc_q + CNT_W'(cyc_inc) + CNT_W'(step_entry);

   always_ff @(posedge sys_clk or negedge sys_reset_n) begin
      if (!sys_reset_n) begin
         state_q    <= IDLE;
         tmr_q      <= '0;
         steps_q    <= '0;
         bp_q       <= '0;
         cyc_q      <= '0;
         rsp_q      <= '0;
         clk_en_q   <= 1'b0;
         clk_step_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         tmr_q      <= tmr_d;
         steps_q    <= steps_d;
         bp_q       <= bp_d;
         cyc_q      <= cyc_d;
         rsp_q      <= rsp_d;
         clk_en_q   <= clk_en_d;
         clk_step_q <= clk_step_d;
      end
   end

endmodule

// File: tb/tb_il_debug_sequencer.sv
// Self-checking bench for il_debug_sequencer against a cycle-level behavioural model.
// Honours IL_SEQ_AUTO_HALT_EN for the auto-halt expectations.
module tb_il_debug_sequencer;

   localparam int unsigned CNT_W = 32;
   localparam int unsigned H     = 4;
   localparam int unsigned L     = 4;
`ifdef IL_SEQ_AUTO_HALT_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif
   localparam logic [2:0] NOP = 3'd0, SET_BP = 3'd1, RUN = 3'd2, HALT = 3'd3, STEP = 3'd4,
                          RD_STATUS = 3'd5, RD_CYCLES = 3'd6, CLR_CYCLES = 3'd7;

   logic             sys_clk, sys_reset_n, cmd_valid, cmd_ready, rsp_valid, rsp_ready;
   logic             break_in, clk_en, clk_step;
   logic [2:0]       cmd_op;
   logic [CNT_W-1:0] cmd_arg, rsp_data, breakpoint;

   int checks = 0;
   int errors = 0;

   // behavioural model state
   bit               m_clk_en, m_in_resp, m_rsp_stat, m_sticky, m_brk_prev;
   logic [CNT_W-1:0] m_bp, m_cycles, m_rsp;
   int unsigned      m_busy, m_total;

   il_debug_sequencer #(.CNT_W(CNT_W), .STEP_HIGH(H), .STEP_LOW(L)) dut (
      .sys_clk(sys_clk), .sys_reset_n(sys_reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .break_in(break_in), .clk_en(clk_en), .breakpoint(breakpoint), .clk_step(clk_step)
   );

   initial begin
      sys_clk = 1'b0;
      forever #5 sys_clk = ~sys_clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running at limit");
      $fatal(1, "watchdog");
   end

   function automatic bit m_ready();
      return !m_in_resp && m_busy == 0;
   endfunction

   function automatic bit m_step_level();
      int unsigned k;
      k = m_total - m_busy;
      return (m_busy != 0) && ((k % (H + L)) < H);
   endfunction

   task automatic model_reset();
      m_clk_en = 0; m_in_resp = 0; m_rsp_stat = 0; m_sticky = 0; m_brk_prev = 0;
      m_bp = '0; m_cycles = '0; m_rsp = '0; m_busy = 0; m_total = 0;
   endtask

   // Advance one clock from a falling edge to the next, applying the model at the rising edge.
   task automatic tick();
      bit ready, acc, brk, rdy, pre_en, pre_sticky, rise;
      logic [2:0] op;
      logic [CNT_W-1:0] arg, pre_cyc;
      ready = m_ready();
      acc = cmd_valid && ready;
      op = cmd_op; arg = cmd_arg; brk = break_in; rdy = rsp_ready;
      pre_en = m_clk_en; pre_sticky = m_sticky; pre_cyc = m_cycles;
      rise = AUTO && brk && !m_brk_prev;
      @(posedge sys_clk);
      if (pre_en && !brk) m_cycles = m_cycles + CNT_W'(1);
      if (m_busy != 0) m_busy--;
      if (m_in_resp && rdy) begin
         m_in_resp = 0;
         if (m_rsp_stat) m_sticky = 0;
      end
      if (acc) begin
         case (op)
            SET_BP:     m_bp = arg;
            RUN:        m_clk_en = 1;
            HALT:       m_clk_en = 0;
            CLR_CYCLES: m_cycles = '0;
            STEP: if (arg != '0) begin
               m_busy = arg * (H + L);
               m_total = m_busy;
               m_cycles = m_cycles + arg;
            end
            RD_STATUS: begin
               m_rsp = {{(CNT_W-4){1'b0}}, pre_sticky, 1'b0, brk, pre_en};
               m_in_resp = 1; m_rsp_stat = 1;
            end
            RD_CYCLES: begin
               m_rsp = pre_cyc;
               m_in_resp = 1; m_rsp_stat = 0;
            end
            default: ;
         endcase
      end
      if (rise) begin
         m_clk_en = 0;
         m_sticky = 1;
      end
      m_brk_prev = brk;
      @(negedge sys_clk);
   endtask

   task automatic send(input logic [2:0] op, input logic [CNT_W-1:0] arg);
      int unsigned n = 0;
      while (!m_ready() && n < 1000) begin
         tick();
         n++;
      end
      if (n == 1000) begin
         checks++; errors++;
         $display("FAIL send_wait: model never became ready for op %0d", op);
      end
      cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
      tick();
      cmd_valid = 1'b0; cmd_op = NOP;
   endtask

   task automatic drain(input int unsigned stall);
      rsp_ready = 1'b0;
      repeat (stall) tick();
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      sys_reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = NOP; cmd_arg = '0;
      rsp_ready = 1'b0; break_in = 1'b0;
      model_reset();
      #1;
      checks++;
      if ({clk_en, clk_step, rsp_valid, cmd_ready} !== 4'b0000 || breakpoint !== '0 || rsp_data !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got en=%b step=%b rv=%b rdy=%b bp=%h rd=%h, required all 0",
                  clk_en, clk_step, rsp_valid, cmd_ready, breakpoint, rsp_data);
      end
      @(negedge sys_clk);
      @(negedge sys_clk);
      sys_reset_n = 1'b1;
      #1;
      checks++;
      if (cmd_ready !== 1'b1 || clk_en !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: got rdy=%b en=%b, required rdy=1 en=0", cmd_ready, clk_en);
      end
   endtask

   task automatic test_set_bp_run();
      int unsigned k;
      k = $urandom_range(20, 40);
      break_in = 1'b0;
      send(CLR_CYCLES, '0);
      send(SET_BP, CNT_W'(100));
      checks++;
      if (breakpoint !== CNT_W'(100)) begin
         errors++;
         $display("FAIL set_bp: got %0d, required 100", breakpoint);
      end
      send(RUN, '0);
      checks++;
      if (clk_en !== 1'b1) begin
         errors++;
         $display("FAIL run: got clk_en=%b, required 1", clk_en);
      end
      repeat (k) tick();
      break_in = 1'b1;
      repeat (3) tick();
      checks++;
      if (clk_en !== m_clk_en) begin
         errors++;
         $display("FAIL run_during_break: got clk_en=%b, required %b", clk_en, m_clk_en);
      end
      send(RD_CYCLES, '0);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== CNT_W'(k) || rsp_data !== m_rsp) begin
         errors++;
         $display("FAIL rd_cycles: got rv=%b data=%0d, required rv=1 data=%0d", rsp_valid, rsp_data, k);
      end
      drain(2);
      break_in = 1'b0;
      send(HALT, '0);
   endtask

   task automatic test_step(input int unsigned n);
      int unsigned total, rises, low;
      bit prev, exp_step, exp_rdy;
      total = n * (H + L); rises = 0; low = 0; prev = 0;
      break_in = 1'b0;
      send(HALT, '0);
      send(CLR_CYCLES, '0);
      send(STEP, CNT_W'(n));
      for (int unsigned k = 0; k < total + 3; k++) begin
         exp_step = (k < total) && ((k % (H + L)) < H);
         exp_rdy  = (k >= total);
         checks++;
         if (clk_step !== exp_step || cmd_ready !== exp_rdy) begin
            errors++;
            $display("FAIL step%0d_cycle%0d: got step=%b rdy=%b, required step=%b rdy=%b",
                     n, k, clk_step, cmd_ready, exp_step, exp_rdy);
         end
         if (clk_step === 1'b1 && !prev) rises++;
         prev = (clk_step === 1'b1);
         if (cmd_ready !== 1'b1) low++;
         tick();
      end
      checks++;
      if (rises != n || low != total) begin
         errors++;
         $display("FAIL step%0d_totals: got rises=%0d busy=%0d, required rises=%0d busy=%0d",
                  n, rises, low, n, total);
      end
      send(RD_CYCLES, '0);
      checks++;
      if (rsp_data !== CNT_W'(n)) begin
         errors++;
         $display("FAIL step%0d_cycles: got %0d, required %0d", n, rsp_data, n);
      end
      drain(0);
   endtask

   task automatic test_resp_stall();
      logic [CNT_W-1:0] held;
      break_in = 1'b0;
      send(RUN, '0);
      send(RD_STATUS, '0);
      held = rsp_data;
      checks++;
      if (rsp_data[2:0] !== 3'b001 || rsp_data !== m_rsp) begin
         errors++;
         $display("FAIL status_run: got %h, required %h", rsp_data, m_rsp);
      end
      rsp_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (rsp_valid !== 1'b1 || rsp_data !== held || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL resp_hold%0d: got rv=%b data=%h rdy=%b, required rv=1 data=%h rdy=0",
                     i, rsp_valid, rsp_data, cmd_ready, held);
         end
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      checks++;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL resp_release: got rv=%b rdy=%b, required rv=0 rdy=1", rsp_valid, cmd_ready);
      end
      send(HALT, '0);
   endtask

   task automatic test_auto_halt();
      logic [CNT_W-1:0] exp1, exp2;
      bit exp_en;
`ifdef IL_SEQ_AUTO_HALT_EN
      exp_en = 1'b0; exp1 = CNT_W'(4'hA); exp2 = CNT_W'(4'h2);
`else
      exp_en = 1'b1; exp1 = CNT_W'(4'h3); exp2 = CNT_W'(4'h3);
`endif
      break_in = 1'b0;
      send(HALT, '0);
      send(RD_STATUS, '0);
      drain(0);
      send(RUN, '0);
      repeat (3) tick();
      break_in = 1'b1;
      tick();
      checks++;
      if (clk_en !== exp_en) begin
         errors++;
         $display("FAIL auto_halt_en: got clk_en=%b, required %b", clk_en, exp_en);
      end
      send(RD_STATUS, '0);
      checks++;
      if (rsp_data !== exp1) begin
         errors++;
         $display("FAIL status_first: got %h, required %h", rsp_data, exp1);
      end
      drain(1);
      send(RD_STATUS, '0);
      checks++;
      if (rsp_data !== exp2) begin
         errors++;
         $display("FAIL status_second: got %h, required %h", rsp_data, exp2);
      end
      drain(0);
      break_in = 1'b0;
      send(HALT, '0);
   endtask

   task automatic test_back_to_back();
      logic [CNT_W-1:0] a, b;
      a = $urandom(); b = $urandom();
      send(SET_BP, a);
      checks++;
      if (breakpoint !== a) begin
         errors++;
         $display("FAIL b2b_bp_a: got %h, required %h", breakpoint, a);
      end
      send(RUN, '0);
      send(SET_BP, b);
      checks++;
      if (breakpoint !== b || clk_en !== 1'b1) begin
         errors++;
         $display("FAIL b2b_bp_b: got bp=%h en=%b, required bp=%h en=1", breakpoint, clk_en, b);
      end
      send(HALT, '0);
      checks++;
      if (clk_en !== 1'b0 || cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL b2b_halt: got en=%b rdy=%b, required en=0 rdy=1", clk_en, cmd_ready);
      end
   endtask

   task automatic test_random();
      logic [2:0] op;
      logic [CNT_W-1:0] arg;
      for (int it = 0; it < 80; it++) begin
         op = 3'($urandom_range(0, 7));
         arg = (op == STEP) ? CNT_W'($urandom_range(0, 2)) : CNT_W'($urandom());
         if ($urandom_range(0, 3) == 0) break_in = ~break_in;
         checks++;
         if (cmd_ready !== m_ready() || clk_en !== m_clk_en || breakpoint !== m_bp || clk_step !== m_step_level()) begin
            errors++;
            $display("FAIL rand%0d_state: got rdy=%b en=%b bp=%h step=%b, required rdy=%b en=%b bp=%h step=%b",
                     it, cmd_ready, clk_en, breakpoint, clk_step, m_ready(), m_clk_en, m_bp, m_step_level());
         end
         send(op, arg);
         if (op == RD_STATUS || op == RD_CYCLES) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== m_rsp) begin
               errors++;
               $display("FAIL rand%0d_rsp op%0d: got rv=%b data=%h, required rv=1 data=%h",
                        it, op, rsp_valid, rsp_data, m_rsp);
            end
            drain($urandom_range(0, 3));
         end
         repeat ($urandom_range(0, 3)) tick();
      end
      break_in = 1'b0;
      send(HALT, '0);
   endtask

   task automatic test_reset_midstream();
      send(RUN, '0);
      send(SET_BP, CNT_W'(32'h55));
      send(STEP, CNT_W'(2));
      tick();
      tick();
      checks++;
      if (clk_step !== 1'b1) begin
         errors++;
         $display("FAIL mid_step_level: got %b, required 1", clk_step);
      end
      #2 sys_reset_n = 1'b0;
      #1;
      checks++;
      if ({clk_en, clk_step, rsp_valid, cmd_ready} !== 4'b0000 || breakpoint !== '0) begin
         errors++;
         $display("FAIL mid_step_reset: got en=%b step=%b rv=%b rdy=%b bp=%h, required all 0",
                  clk_en, clk_step, rsp_valid, cmd_ready, breakpoint);
      end
      @(negedge sys_clk);
      sys_reset_n = 1'b1;
      model_reset();
      #1;
      send(RD_STATUS, '0);
      rsp_ready = 1'b0;
      tick();
      tick();
      #2 sys_reset_n = 1'b0;
      #1;
      checks++;
      if (rsp_valid !== 1'b0 || rsp_data !== '0 || cmd_ready !== 1'b0) begin
         errors++;
         $display("FAIL mid_resp_reset: got rv=%b data=%h rdy=%b, required 0", rsp_valid, rsp_data, cmd_ready);
      end
      @(negedge sys_clk);
      sys_reset_n = 1'b1;
      model_reset();
      #1;
      tick();
      checks++;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL resp_discarded: got rv=%b rdy=%b, required rv=0 rdy=1", rsp_valid, cmd_ready);
      end
   endtask

   initial begin
      test_reset();
      test_set_bp_run();
      test_step(3);
      test_step(0);
      test_step(1);
      test_resp_stall();
      test_auto_halt();
      test_back_to_back();
      test_random();
      test_reset_midstream();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
